fetch_unit: RTL and testbench

Instruction fetch initiator for the MIPS-32 core. It owns the program counter and drives addresses into the registered instruction memory. It tracks the one-cycle-registered read responses and buffers the returned words in a small FIFO. Decode receives the words over a valid/ready handshake. Branch/jump redirects flush all buffered and in-flight fetches.

---
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory address/data, redirect input and the
// valid/ready instruction stream toward decode.
interface fetch_unit_if;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, imem_instr, if_ready,
    output imem_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, imem_instr, if_ready,
    input  imem_addr, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch initiator: owns the PC, issues into a registered imem,
// tracks in-flight reads and buffers returned words for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 2;

  logic [31:0]      r_pc;
  logic [31:0]      r_imem_addr;
  logic [31:0]      r_rsp_pc;
  logic             r_iss_q;
  logic             r_rsp_q;
  logic [31:0]      r_fifo_pc    [DEPTH];
  logic [31:0]      r_fifo_instr [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [31:0]      w_target;
  logic [CRD_W-1:0] w_credit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid & bus.if_ready;
  assign w_push   = r_rsp_q;
  assign w_target = bus.redirect_pc & ~32'd3;

  // Words already owed to the FIFO (buffered + both pipeline stages) minus
  // the one leaving this cycle; a pop cannot occur with an empty FIFO.
  assign w_credit = CRD_W'(r_count) + CRD_W'(r_iss_q) + CRD_W'(r_rsp_q)
                  - CRD_W'(w_pop);
  assign w_issue  = bus.fetch_en & (w_credit < CRD_W'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_imem_addr <= RESET_PC;
      r_rsp_pc    <= '0;
      r_iss_q     <= 1'b0;
      r_rsp_q     <= 1'b0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else if (bus.redirect_valid) begin
      r_imem_addr <= w_target;
      r_pc        <= w_target + 32'd4;
      r_iss_q     <= bus.fetch_en;
      r_rsp_q     <= 1'b0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else begin
      if (w_issue) begin
        r_imem_addr <= r_pc;
        r_pc        <= r_pc + 32'd4;
      end
      r_iss_q  <= w_issue;
      r_rsp_q  <= r_iss_q;
      r_rsp_pc <= r_imem_addr;
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !bus.redirect_valid) begin
      r_fifo_pc[r_wr_ptr]    <= r_rsp_pc;
      r_fifo_instr[r_wr_ptr] <= bus.imem_instr;
    end
  end

  assign bus.imem_addr = r_imem_addr;
  assign bus.if_valid  = w_valid;
  assign bus.if_pc     = w_valid ? r_fifo_pc[r_rd_ptr]    : 32'd0;
  assign bus.if_instr  = w_valid ? r_fifo_instr[r_rd_ptr] : 32'd0;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic checked
// against a program-order stream model with a synthetic instruction memory.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h012A_4020;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_C3C3;
  endfunction

  always @(posedge clk) bus.imem_instr <= mem_word(bus.imem_addr);

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_pc;
  int          since;
  logic        redir_fe;
  logic        hold_pend;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  logic        must_valid;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic [31:0] occ;
    logic [31:0] target;
    if (must_valid) check_val("stream_valid", 32'(bus.if_valid), 32'd1);
    if (hold_pend) begin
      check_val("hold_valid", 32'(bus.if_valid), 32'd1);
      check_val("hold_pc", bus.if_pc, hold_pc);
      check_val("hold_instr", bus.if_instr, hold_instr);
    end
    if (bus.if_valid) begin
      check_val("head_pc", bus.if_pc, exp_pc);
      check_val("head_instr", bus.if_instr, mem_word(exp_pc));
    end else begin
      check_val("empty_pc", bus.if_pc, 32'd0);
      check_val("empty_instr", bus.if_instr, 32'd0);
    end
    if (since == 0 || since == 1) check_val("redir_gap", 32'(bus.if_valid), 32'd0);
    if (since == 2 && redir_fe) check_val("redir_latency", 32'(bus.if_valid), 32'd1);
    // Issued-but-unconsumed words in program order never exceed DEPTH.
    occ = (bus.imem_addr + 32'd4 - exp_pc) >> 2;
    check_val("occupancy", 32'(occ <= 32'(DEPTH)), 32'd1);

    hold_pend  = bus.if_valid & ~bus.if_ready & ~bus.redirect_valid;
    hold_pc    = bus.if_pc;
    hold_instr = bus.if_instr;
    if (bus.if_valid && bus.if_ready) exp_pc = exp_pc + 32'd4;
    if (bus.redirect_valid) begin
      // With fetch disabled the target itself is skipped; the PC moves past it.
      target   = bus.redirect_pc & ~32'd3;
      exp_pc   = bus.fetch_en ? target : target + 32'd4;
      since    = 0;
      redir_fe = bus.fetch_en;
    end else if (since == -1) begin
      since    = 0;
      redir_fe = bus.fetch_en;
    end else if (since < 3) begin
      since++;
    end
  endtask

  task automatic do_cycle(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
    bus.fetch_en       = fe;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.if_ready       = rdy;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.redirect_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("rst_valid", 32'(bus.if_valid), 32'd0);
    check_val("rst_imem_addr", bus.imem_addr, RESET_PC);
    check_val("rst_if_pc", bus.if_pc, 32'd0);
    check_val("rst_if_instr", bus.if_instr, 32'd0);
    #1;
    rst_n      = 1'b1;
    exp_pc     = RESET_PC;
    since      = -1;
    redir_fe   = 1'b0;
    hold_pend  = 1'b0;
    must_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic        fe, rv, rdy;
    logic [31:0] rpc;
    bus.fetch_en       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.if_ready       = 1'b0;
    must_valid         = 1'b0;
    hold_pend          = 1'b0;
    since              = 3;
    exp_pc             = RESET_PC;
    redir_fe           = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset release and steady fetch.
    do_reset();
    repeat (3) do_cycle(1'b1, 1'b0, 32'd0, 1'b1);
    must_valid = 1'b1;
    repeat (4) do_cycle(1'b1, 1'b0, 32'd0, 1'b1);
    must_valid = 1'b0;

    // Backpressure from reset.
    do_reset();
    repeat (10) do_cycle(1'b1, 1'b0, 32'd0, 1'b0);
    check_val("bp_imem_addr", bus.imem_addr, 32'h0000_000C);
    check_val("bp_head_pc", bus.if_pc, 32'd0);
    must_valid = 1'b1;
    repeat (5) do_cycle(1'b1, 1'b0, 32'd0, 1'b1);
    must_valid = 1'b0;

    // Redirect with 0x08 and 0x0C in flight.
    do_reset();
    repeat (4) do_cycle(1'b1, 1'b0, 32'd0, 1'b1);
    check_val("inflight_addr", bus.imem_addr, 32'h0000_000C);
    do_cycle(1'b1, 1'b1, 32'h0000_0040, 1'b1);
    repeat (4) do_cycle(1'b1, 1'b0, 32'd0, 1'b1);

    // Misaligned redirect.
    do_cycle(1'b1, 1'b1, 32'h0000_0043, 1'b1);
    check_val("misalign_addr", bus.imem_addr, 32'h0000_0040);
    repeat (2) do_cycle(1'b1, 1'b0, 32'd0, 1'b0);
    check_val("misalign_if_pc", bus.if_pc, 32'h0000_0040);
    repeat (2) do_cycle(1'b1, 1'b0, 32'd0, 1'b1);

    // Wrap-around.
    do_cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (2) do_cycle(1'b1, 1'b0, 32'd0, 1'b1);
    must_valid = 1'b1;
    repeat (3) do_cycle(1'b1, 1'b0, 32'd0, 1'b1);
    must_valid = 1'b0;

    // Redirect coinciding with a pop of a full FIFO.
    repeat (6) do_cycle(1'b1, 1'b0, 32'd0, 1'b0);
    do_cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    repeat (4) do_cycle(1'b1, 1'b0, 32'd0, 1'b1);

    // fetch_en low drains in-flight words without new issue.
    repeat (4) do_cycle(1'b1, 1'b0, 32'd0, 1'b1);
    a = bus.imem_addr;
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b0, 1'b0, 32'd0, 1'b1);
      check_val("fe_low_addr", bus.imem_addr, a);
    end
    check_val("fe_low_drained_pc", a + 32'd4, exp_pc);
    check_val("fe_low_empty", 32'(bus.if_valid), 32'd0);

    // Reset in the middle of a stream.
    repeat (5) do_cycle(1'b1, 1'b0, 32'd0, 1'b1);
    do_reset();
    repeat (3) do_cycle(1'b1, 1'b0, 32'd0, 1'b1);
    must_valid = 1'b1;
    repeat (3) do_cycle(1'b1, 1'b0, 32'd0, 1'b1);
    must_valid = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      fe  = ($urandom % 8) != 0;
      rdy = ($urandom % 3) != 0;
      rv  = ($urandom % 16) == 0;
      case ($urandom % 4)
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF0 + ($urandom % 16);
        2:       rpc = $urandom % 256;
        default: rpc = 32'h0000_1000 + ($urandom % 64);
      endcase
      if (($urandom % 500) == 0) do_reset();
      do_cycle(fe, rv, rpc, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
